// File: rtl/track_pkg.sv
// Shared types and constants for the track section controller.
package track_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SETUP    = 2'd1,
    ST_OCCUPIED = 2'd2,
    ST_FAULT    = 2'd3
  } track_state_t;

  localparam logic [1:0] DIR_GO   = 2'b01;
  localparam logic [1:0] DIR_STOP = 2'b00;

  localparam int N_TRAINS_DEF    = 4;
  localparam int SW_W_DEF        = 3;
  localparam int SETTLE_CYC_DEF  = 2;
  localparam int TIMEOUT_CYC_DEF = 16;

endpackage

// File: rtl/track_rr_arb.sv
// Round-robin arbiter: picks the lowest requesting index at or above ptr,
// wrapping past the top index back to zero.
module track_rr_arb #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         valid,
  output logic [W-1:0] index
);

  // Scan indices in order ptr, ptr+1, ... wrapping; first hit wins.
  always_comb begin
    int idx;
    idx   = 0;
    valid = 1'b0;
    index = '0;
    for (int off = 0; off < N; off++) begin
      idx = (int'(ptr) + off) % N;
      if (!valid && req[idx]) begin
        valid = 1'b1;
        index = W'(idx);
      end
    end
  end

endmodule

// File: rtl/track_section_ctrl.sv
// Single-section interlock: grants one train at a time, sets the switch
// bank, waits for the switches to settle, then releases the owner until it
// reports exit. Optional occupancy watchdog enabled by TRACK_TIMEOUT_EN:
// a train that stays too long latches FAULT, which only RESET clears.
module track_section_ctrl
  import track_pkg::*;
#(
  parameter int N_TRAINS    = N_TRAINS_DEF,
  parameter int SW_W        = SW_W_DEF,
  parameter int SETTLE_CYC  = SETTLE_CYC_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                        Clock,
  input  logic                        RESET,
  input  logic [N_TRAINS-1:0]         SR_REQ,
  input  logic [N_TRAINS-1:0]         SR_EXIT,
  input  logic [N_TRAINS*SW_W-1:0]    ROUTE,
  output logic [SW_W-1:0]             SW,
  output logic [2*N_TRAINS-1:0]       DIR,
  output logic [$clog2(N_TRAINS)-1:0] OWNER,
  output logic                        BUSY,
  output logic                        FAULT
);

  localparam int OW_W  = $clog2(N_TRAINS);
  localparam int SET_W = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC);

  track_state_t    state;
  logic [OW_W-1:0] ptr;
  logic [OW_W-1:0] next_ptr;
  logic [SET_W-1:0] settle_cnt;
  logic            grant_valid;
  logic [OW_W-1:0] grant_index;
  logic            fault_st;

`ifdef TRACK_TIMEOUT_EN
  localparam int OCC_W = $clog2(TIMEOUT_CYC + 1);
  logic [OCC_W-1:0] occ_cnt;
`endif

  track_rr_arb #(
    .N (N_TRAINS),
    .W (OW_W)
  ) u_arb (
    .req   (SR_REQ),
    .ptr   (ptr),
    .valid (grant_valid),
    .index (grant_index)
  );

  assign next_ptr = (OWNER == OW_W'(N_TRAINS - 1)) ? '0 : OWNER + 1'b1;

`ifdef TRACK_TIMEOUT_EN
  assign fault_st = (state == ST_FAULT);
`else
  assign fault_st = 1'b0;
`endif

  assign BUSY  = (state == ST_SETUP) || (state == ST_OCCUPIED);
  assign FAULT = fault_st;

  // Section FSM: grant, settle switches, occupy, release (or fault).
  always_ff @(posedge Clock) begin
    if (RESET) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      OWNER      <= '0;
      SW         <= '0;
      settle_cnt <= '0;
`ifdef TRACK_TIMEOUT_EN
      occ_cnt    <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            state      <= ST_SETUP;
            OWNER      <= grant_index;
            SW         <= ROUTE[grant_index*SW_W +: SW_W];
            settle_cnt <= SET_W'(SETTLE_CYC - 1);
`ifdef TRACK_TIMEOUT_EN
            occ_cnt    <= '0;
`endif
          end
        end
        ST_SETUP: begin
          // Owner's request may drop here; the setup still completes.
          if (settle_cnt == '0) state <= ST_OCCUPIED;
          else                  settle_cnt <= settle_cnt - 1'b1;
        end
        ST_OCCUPIED: begin
          if (SR_EXIT[OWNER]) begin
            state <= ST_IDLE;
            ptr   <= next_ptr;
          end
`ifdef TRACK_TIMEOUT_EN
          else begin
            if (occ_cnt == OCC_W'(TIMEOUT_CYC - 1)) state <= ST_FAULT;
            if (occ_cnt != '1) occ_cnt <= occ_cnt + 1'b1;
          end
`endif
        end
`ifdef TRACK_TIMEOUT_EN
        ST_FAULT: state <= ST_FAULT;
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Per-train drive: waiting trains stop unless they hold the section.
  always_comb begin
    DIR = '0;
    for (int i = 0; i < N_TRAINS; i++) begin
      if (fault_st ||
          (SR_REQ[i] && !((state == ST_OCCUPIED) && (OWNER == OW_W'(i)))))
        DIR[2*i +: 2] = DIR_STOP;
      else
        DIR[2*i +: 2] = DIR_GO;
    end
  end

endmodule

// File: tb/tb_track_section_ctrl.sv
// Directed bench for track_section_ctrl (N_TRAINS=4, SW_W=3, SETTLE_CYC=2,
// TIMEOUT_CYC=16). Follows TRACK_TIMEOUT_EN for the long-occupancy case.
module tb_track_section_ctrl;

  logic        Clock;
  logic        RESET;
  logic [3:0]  SR_REQ;
  logic [3:0]  SR_EXIT;
  logic [11:0] ROUTE;
  logic [2:0]  SW;
  logic [7:0]  DIR;
  logic [1:0]  OWNER;
  logic        BUSY;
  logic        FAULT;

  int n_checks = 0;
  int n_fail   = 0;

  track_section_ctrl #(
    .N_TRAINS    (4),
    .SW_W        (3),
    .SETTLE_CYC  (2),
    .TIMEOUT_CYC (16)
  ) dut (
    .Clock   (Clock),
    .RESET   (RESET),
    .SR_REQ  (SR_REQ),
    .SR_EXIT (SR_EXIT),
    .ROUTE   (ROUTE),
    .SW      (SW),
    .DIR     (DIR),
    .OWNER   (OWNER),
    .BUSY    (BUSY),
    .FAULT   (FAULT)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  logic [1:0] exp_owner;
  logic [2:0] exp_sw;

  initial begin
    // slice0=011 slice1=110 slice2=101 slice3=010
    ROUTE   = {3'b010, 3'b101, 3'b110, 3'b011};
    RESET   = 1'b1;
    SR_REQ  = 4'b0000;
    SR_EXIT = 4'b0000;
    tick();
    tick();
    RESET = 1'b0;
    tick();

    chk("rst_sw",    SW,    3'b000);
    chk("rst_owner", OWNER, 2'd0);
    chk("rst_busy",  BUSY,  1'b0);
    chk("rst_fault", FAULT, 1'b0);
    chk("rst_dir",   DIR,   8'h55);

    // Single request from train 2
    SR_REQ = 4'b0100;
    #1;
    chk("idle_req_dir", DIR, 8'h45);
    tick();
    chk("t2_sw",    SW,    3'b101);
    chk("t2_owner", OWNER, 2'd2);
    chk("t2_busy",  BUSY,  1'b1);
    chk("t2_dir_s1", DIR[5:4], 2'b00);
    tick();
    chk("t2_dir_s2", DIR[5:4], 2'b00);
    chk("t2_sw_hold", SW, 3'b101);
    tick();
    chk("t2_dir_occ", DIR, 8'h55);
    chk("t2_busy_occ", BUSY, 1'b1);
    SR_REQ  = 4'b0000;
    SR_EXIT = 4'b0100;
    tick();
    chk("t2_exit_busy", BUSY, 1'b0);
    SR_EXIT = 4'b0000;

    // PTR is 3 now; train 1 takes the section, non-owner exit ignored
    SR_REQ = 4'b0010;
    tick();
    chk("t1_owner", OWNER, 2'd1);
    chk("t1_sw",    SW,    3'b110);
    tick();
    tick();
    chk("t1_dir_occ", DIR, 8'h55);
    SR_REQ  = 4'b0000;
    SR_EXIT = 4'b0001;
    tick();
    chk("t1_ignore_busy",  BUSY,  1'b1);
    chk("t1_ignore_owner", OWNER, 2'd1);
    SR_EXIT = 4'b0010;
    tick();
    chk("t1_exit_busy", BUSY, 1'b0);
    SR_EXIT = 4'b0000;

    // PTR should be 2: with 0,1,2 requesting, 2 wins
    SR_REQ = 4'b0111;
    tick();
    chk("ptr2_owner", OWNER, 2'd2);
    chk("ptr2_sw",    SW,    3'b101);
    chk("ptr2_busy",  BUSY,  1'b1);

    // Reset mid-SETUP
    RESET = 1'b1;
    tick();
    chk("rsetup_sw",    SW,    3'b000);
    chk("rsetup_busy",  BUSY,  1'b0);
    chk("rsetup_owner", OWNER, 2'd0);
    RESET  = 1'b0;
    SR_REQ = 4'b0000;
    tick();
    chk("rsetup_idle", BUSY, 1'b0);

    // All four requesting: order 0,1,2,3,0 with an idle cycle between
    SR_REQ = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      exp_owner = 2'(g % 4);
      case (exp_owner)
        2'd0: exp_sw = 3'b011;
        2'd1: exp_sw = 3'b110;
        2'd2: exp_sw = 3'b101;
        default: exp_sw = 3'b010;
      endcase
      tick();
      chk("rr_owner", OWNER, exp_owner);
      chk("rr_sw",    SW,    exp_sw);
      chk("rr_busy",  BUSY,  1'b1);
      chk("rr_dir_setup", DIR, 8'h00);
      tick();
      tick();
      chk("rr_dir_occ", DIR, 8'h01 << (2 * exp_owner));
      SR_EXIT = 4'b0001 << exp_owner;
      tick();
      chk("rr_idle_gap", BUSY, 1'b0);
      SR_EXIT = 4'b0000;
      if (g == 4) SR_REQ = 4'b0000;
    end
    tick();
    chk("rr_done_idle", BUSY, 1'b0);

    // Long occupancy by train 0 (PTR=1, wraps to 0)
    SR_REQ = 4'b0001;
    tick();
    chk("to_owner", OWNER, 2'd0);
    tick();
    tick();
    SR_REQ = 4'b0000;
    for (int c = 0; c < 15; c++) tick();
    chk("to_pre_fault", FAULT, 1'b0);
    chk("to_pre_busy",  BUSY,  1'b1);
    tick();
`ifdef TRACK_TIMEOUT_EN
    chk("to_fault",    FAULT, 1'b1);
    chk("to_fault_dir", DIR,  8'h00);
    chk("to_fault_sw",  SW,   3'b011);
    chk("to_fault_busy", BUSY, 1'b0);
    SR_EXIT = 4'b0001;
    tick();
    chk("to_fault_sticky", FAULT, 1'b1);
    SR_EXIT = 4'b0000;
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    chk("to_rst_fault", FAULT, 1'b0);
    chk("to_rst_busy",  BUSY,  1'b0);
    chk("to_rst_dir",   DIR,   8'h55);
`else
    chk("to_nofault",      FAULT, 1'b0);
    chk("to_nofault_busy", BUSY,  1'b1);
    chk("to_nofault_dir",  DIR,   8'h55);
    SR_EXIT = 4'b0001;
    tick();
    SR_EXIT = 4'b0000;
    chk("to_exit_busy", BUSY, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
